// File: rtl/llr_frame_loader_if.sv
// Stream, read-port and status signals of the LLR ping-pong frame loader.
// The loader connects through the slave modport; the feeding and decoding side uses master.
interface llr_frame_loader_if #(
  parameter int W     = 16,
  parameter int LOG2N = 8
);
  // Handshake: a sample moves only on a rising edge where in_valid and in_ready are both high.
  // in_valid may not depend on in_ready. in_ready depends only on registered state.
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_llr;
  logic             in_last;
  logic             frame_valid;
  logic [LOG2N-1:0] rd_addr;
  logic [W-1:0]     rd_llr;
  logic             rd_hard;
  logic             frame_done;
  logic             len_err;
  logic [15:0]      frame_cnt;

  modport slave (
    input  in_valid, in_llr, in_last, rd_addr, frame_done,
    output in_ready, frame_valid, rd_llr, rd_hard, len_err, frame_cnt
  );

  modport master (
    output in_valid, in_llr, in_last, rd_addr, frame_done,
    input  in_ready, frame_valid, rd_llr, rd_hard, len_err, frame_cnt
  );
endinterface

// File: rtl/llr_frame_loader.sv
// Two-bank ping-pong LLR frame buffer with length check and a one-cycle registered read port.
// Optional feature macro LLR_SAT_EN: clamp every stored sample to [-LLR_MAX, +LLR_MAX].
module llr_frame_loader #(
  parameter int N     = 204,
  parameter int LOG2N = 8,
  parameter int INT   = 8,
  parameter int FRAC  = 8
`ifdef LLR_SAT_EN
  , parameter logic [INT+FRAC-1:0] LLR_MAX = 16'h1000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  llr_frame_loader_if.slave bus
);
  localparam int W = INT + FRAC;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [W-1:0]     mem0 [N];
  logic [W-1:0]     mem1 [N];
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_ptr;
  logic [W-1:0]     wr_data;
  logic [W-1:0]     rd_word;
  logic             accept;
  logic             at_end;
  logic             good_end;
  logic             bad_len;
  logic             done_ok;

  assign bus.in_ready    = ~full[wr_bank];
  assign bus.frame_valid = full[rd_bank];

  assign accept   = bus.in_valid & ~full[wr_bank];
  assign at_end   = (wr_ptr == LAST);
  assign good_end = accept & bus.in_last & at_end;
  assign bad_len  = accept & (bus.in_last ^ at_end);
  assign done_ok  = bus.frame_done & full[rd_bank];

`ifdef LLR_SAT_EN
  localparam logic signed [W-1:0] SAT_HI = LLR_MAX;
  localparam logic signed [W-1:0] SAT_LO = -$signed(LLR_MAX);

  always_comb begin
    wr_data = bus.in_llr;
    if ($signed(bus.in_llr) > SAT_HI)      wr_data = SAT_HI;
    else if ($signed(bus.in_llr) < SAT_LO) wr_data = SAT_LO;
  end
`else
  assign wr_data = bus.in_llr;
`endif

  // Bank storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_bank) mem1[wr_ptr] <= wr_data;
      else         mem0[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (bus.rd_addr <= LAST) rd_word = rd_bank ? mem1[bus.rd_addr] : mem0[bus.rd_addr];
  end

  // A completing bank and a released bank are always different banks, so both updates compose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full          <= 2'b00;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_ptr        <= '0;
      bus.len_err   <= 1'b0;
      bus.frame_cnt <= '0;
      bus.rd_llr    <= '0;
      bus.rd_hard   <= 1'b1;
    end else begin
      bus.len_err <= bad_len;
      bus.rd_llr  <= rd_word;
      bus.rd_hard <= ~rd_word[W-1];
      if (good_end) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
        bus.frame_cnt <= bus.frame_cnt + 16'd1;
      end
      if (done_ok) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (accept) begin
        if (good_end || bad_len) wr_ptr <= '0;
        else                     wr_ptr <= wr_ptr + LOG2N'(1);
      end
    end
  end
endmodule

// File: tb/tb_llr_frame_loader.sv
// Self-checking bench for llr_frame_loader: frame loading, ping-pong, length errors,
// optional saturation (LLR_SAT_EN), overlapped completion/release and mid-frame reset.
module tb_llr_frame_loader;
  localparam int N = 204;

  logic clk;
  logic rst;
  llr_frame_loader_if #(.W(16), .LOG2N(8)) bus ();

  llr_frame_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [15:0] exp_cnt;
  logic [15:0] exp_q [$];
  logic [15:0] stim [4][N];

  task automatic fill_random(input int slot);
    for (int i = 0; i < N; i++) stim[slot][i] = 16'($urandom);
  endtask

  // Drives len samples back to back starting and ending at a falling edge.
  task automatic send_frame(input int slot, input int len, input int last_idx, input bit done_at_last);
    int guard;
    for (int i = 0; i < len; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_llr     = stim[slot][i];
      bus.in_last    = (i == last_idx);
      bus.frame_done = done_at_last && (i == len - 1);
      guard = 0;
      while (!bus.in_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) begin
        checks++; errors++;
        $display("FAIL ready_timeout sample %0d got in_ready=0 want 1", i);
      end
      @(negedge clk);
    end
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.frame_done = 1'b0;
  endtask

  task automatic read_check(input int addr, input logic [15:0] exp, input string name);
    logic [15:0] e;
    bus.rd_addr = 8'(addr);
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.rd_llr !== e) begin
      errors++;
      $display("FAIL %s rd_llr addr %0d got %h want %h", name, addr, bus.rd_llr, e);
    end
    checks++;
    if (bus.rd_hard !== ~e[15]) begin
      errors++;
      $display("FAIL %s rd_hard addr %0d got %b want %b", name, addr, bus.rd_hard, ~e[15]);
    end
  endtask

  task automatic pulse_done();
    bus.frame_done = 1'b1;
    @(negedge clk);
    bus.frame_done = 1'b0;
  endtask

  task automatic check_status(input string name, input logic fv, input logic rdy);
    checks++;
    if (bus.frame_valid !== fv) begin
      errors++;
      $display("FAIL %s frame_valid got %b want %b", name, bus.frame_valid, fv);
    end
    checks++;
    if (bus.in_ready !== rdy) begin
      errors++;
      $display("FAIL %s in_ready got %b want %b", name, bus.in_ready, rdy);
    end
    checks++;
    if (bus.frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d want %0d", name, bus.frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_llr = '0; bus.in_last = 1'b0;
    bus.rd_addr = '0; bus.frame_done = 1'b0;
    exp_cnt = '0;
    #3;
    check_status("reset", 1'b0, 1'b1);
    checks++;
    if (bus.rd_llr !== 16'h0000) begin errors++; $display("FAIL reset rd_llr got %h want 0000", bus.rd_llr); end
    checks++;
    if (bus.rd_hard !== 1'b1) begin errors++; $display("FAIL reset rd_hard got %b want 1", bus.rd_hard); end
    checks++;
    if (bus.len_err !== 1'b0) begin errors++; $display("FAIL reset len_err got %b want 0", bus.len_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < N; i++) stim[0][i] = 16'(i << 8);
    send_frame(0, N, N - 1, 1'b0);
    exp_cnt++;
    check_status("basic_done", 1'b1, 1'b1);
    read_check(5, 16'h0500, "basic");
    read_check(0, 16'h0000, "basic");
    read_check(203, 16'hCB00, "basic");
    read_check(210, 16'h0000, "basic_oob");
    read_check(255, 16'h0000, "basic_oob");
    pulse_done();
    check_status("basic_release", 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    fill_random(0);
    fill_random(1);
    send_frame(0, N, N - 1, 1'b0);
    send_frame(1, N, N - 1, 1'b0);
    exp_cnt += 16'd2;
    check_status("b2b_full", 1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_llr = 16'h1234; bus.in_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_status("b2b_stall", 1'b1, 1'b0);
    end
    bus.in_valid = 1'b0;
    read_check(7, stim[0][7], "b2b_a");
    pulse_done();
    check_status("b2b_swap", 1'b1, 1'b1);
    read_check(7, stim[1][7], "b2b_b");
    read_check(100, stim[1][100], "b2b_b");
    pulse_done();
    check_status("b2b_empty", 1'b0, 1'b1);
  endtask

  task automatic test_len_err();
    fill_random(2);
    send_frame(2, 100, 99, 1'b0);
    checks++;
    if (bus.len_err !== 1'b1) begin errors++; $display("FAIL short_len_err got %b want 1", bus.len_err); end
    check_status("short", 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.len_err !== 1'b0) begin errors++; $display("FAIL short_len_err_drop got %b want 0", bus.len_err); end
    fill_random(3);
    send_frame(3, N, N - 1, 1'b0);
    exp_cnt++;
    check_status("after_short", 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      int a;
      a = $urandom_range(0, N - 1);
      read_check(a, stim[3][a], "after_short");
    end
    pulse_done();
    send_frame(2, N, -1, 1'b0);
    checks++;
    if (bus.len_err !== 1'b1) begin errors++; $display("FAIL long_len_err got %b want 1", bus.len_err); end
    check_status("long", 1'b0, 1'b1);
    fill_random(3);
    send_frame(3, N, N - 1, 1'b0);
    exp_cnt++;
    check_status("after_long", 1'b1, 1'b1);
    read_check(0, stim[3][0], "after_long");
    read_check(N - 1, stim[3][N - 1], "after_long");
    pulse_done();
  endtask

  task automatic test_saturation();
    logic [15:0] exp0, exp1, exp2;
    for (int i = 0; i < N; i++) stim[2][i] = 16'($urandom_range(0, 16'h1FFF)) - 16'h1000;
    stim[2][0] = 16'h7FFF;
    stim[2][1] = 16'h8000;
    stim[2][2] = 16'h0800;
`ifdef LLR_SAT_EN
    exp0 = 16'h1000; exp1 = 16'hF000; exp2 = 16'h0800;
`else
    exp0 = 16'h7FFF; exp1 = 16'h8000; exp2 = 16'h0800;
`endif
    send_frame(2, N, N - 1, 1'b0);
    exp_cnt++;
    check_status("sat_load", 1'b1, 1'b1);
    read_check(0, exp0, "sat_pos");
    read_check(1, exp1, "sat_neg");
    read_check(2, exp2, "sat_mid");
    read_check(50, stim[2][50], "sat_inrange");
    pulse_done();
  endtask

  task automatic test_overlap();
    fill_random(0);
    fill_random(1);
    send_frame(0, N, N - 1, 1'b0);
    exp_cnt++;
    check_status("overlap_p", 1'b1, 1'b1);
    send_frame(1, N, N - 1, 1'b1);
    exp_cnt++;
    check_status("overlap_q", 1'b1, 1'b1);
    read_check(3, stim[1][3], "overlap_q");
    read_check(180, stim[1][180], "overlap_q");
  endtask

  task automatic test_reset_mid_frame();
    fill_random(2);
    send_frame(2, 100, -1, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_cnt = '0;
    check_status("mid_reset", 1'b0, 1'b1);
    checks++;
    if (bus.rd_hard !== 1'b1) begin errors++; $display("FAIL mid_reset rd_hard got %b want 1", bus.rd_hard); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random(3);
    send_frame(3, N, N - 1, 1'b0);
    exp_cnt++;
    check_status("post_reset", 1'b1, 1'b1);
    read_check(0, stim[3][0], "post_reset");
    read_check(150, stim[3][150], "post_reset");
    pulse_done();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_len_err();
    test_saturation();
    test_overlap();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
